// File: rtl/cv32e41s_pkg.sv
// Shared types and constants for the iterative divider.
// Opcode encoding matches the RV32M decode feeding the EX stage.
package cv32e41s_pkg;

    typedef enum logic [1:0] {
        DIV_DIVU = 2'b00,
        DIV_DIV  = 2'b01,
        DIV_REMU = 2'b10,
        DIV_REM  = 2'b11
    } div_opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_e;

    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_OVF_QUOT  = 32'h8000_0000;

    // Final sign fix and special-case override of the unsigned magnitudes.
    function automatic logic [31:0] div_final(
        input div_opcode_e op,
        input logic        sign_a,
        input logic        sign_b,
        input logic        div_zero,
        input logic        div_ovf,
        input logic [31:0] a_raw,
        input logic [31:0] quot,
        input logic [31:0] rem
    );
        logic        is_rem;
        logic [31:0] q_fix;
        logic [31:0] r_fix;
        is_rem = (op == DIV_REM) || (op == DIV_REMU);
        if (div_zero) begin
            q_fix = DIV_ZERO_QUOT;
            r_fix = a_raw;
        end else if (div_ovf) begin
            q_fix = DIV_OVF_QUOT;
            r_fix = 32'd0;
        end else begin
            q_fix = (sign_a != sign_b) ? (~quot + 32'd1) : quot;
            r_fix = sign_a ? (~rem + 32'd1) : rem;
        end
        return is_rem ? r_fix : q_fix;
    endfunction

endpackage

// File: rtl/cv32e41s_div_iter.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Accepts one operation in IDLE, iterates 32 cycles in CALC, holds result in DONE.
module cv32e41s_div_iter
    import cv32e41s_pkg::*;
#(
    parameter bit EARLY_OUT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    output logic        ready_o,
    input  div_opcode_e operator_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        kill_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o
);

    div_state_e  state_q,  state_d;
    logic [4:0]  cnt_q,    cnt_d;
    div_opcode_e op_q,     op_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic        zero_q,   zero_d;
    logic        ovf_q,    ovf_d;
    logic [31:0] a_raw_q,  a_raw_d;
    logic [31:0] b_abs_q,  b_abs_d;
    logic [31:0] rem_q,    rem_d;
    logic [31:0] quot_q,   quot_d;
    logic [31:0] result_q, result_d;

    logic        signed_in;
    logic        a_neg_in;
    logic        b_neg_in;
    logic [31:0] a_abs_in;
    logic [31:0] b_abs_in;
    logic        zero_in;
    logic        ovf_in;

    logic [32:0] r_shift;
    logic        r_ge;
    logic [31:0] rem_step;
    logic [31:0] quot_step;

    assign signed_in = (operator_i == DIV_DIV) || (operator_i == DIV_REM);
    assign a_neg_in  = signed_in & op_a_i[31];
    assign b_neg_in  = signed_in & op_b_i[31];
    assign a_abs_in  = a_neg_in ? (~op_a_i + 32'd1) : op_a_i;
    assign b_abs_in  = b_neg_in ? (~op_b_i + 32'd1) : op_b_i;
    assign zero_in   = (op_b_i == 32'd0);
    assign ovf_in    = signed_in && (op_a_i == 32'h8000_0000) && (op_b_i == 32'hFFFF_FFFF);

    // Whenever r_ge holds the difference is below |b|, so 32-bit wrap arithmetic is exact.
    assign r_shift   = {rem_q, quot_q[31]};
    assign r_ge      = (r_shift >= {1'b0, b_abs_q});
    assign rem_step  = r_ge ? (r_shift[31:0] - b_abs_q) : r_shift[31:0];
    assign quot_step = {quot_q[30:0], r_ge};

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        a_raw_d  = a_raw_q;
        b_abs_d  = b_abs_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        result_d = result_q;

        unique case (state_q)
            IDLE: begin
                if (valid_i && !kill_i) begin
                    op_d     = operator_i;
                    sign_a_d = a_neg_in;
                    sign_b_d = b_neg_in;
                    zero_d   = zero_in;
                    ovf_d    = ovf_in;
                    a_raw_d  = op_a_i;
                    b_abs_d  = b_abs_in;
                    rem_d    = 32'd0;
                    quot_d   = a_abs_in;
                    cnt_d    = 5'd31;
                    if (EARLY_OUT_EN && (zero_in || ovf_in)) begin
                        state_d  = DONE;
                        result_d = div_final(operator_i, a_neg_in, b_neg_in, zero_in, ovf_in,
                                             op_a_i, 32'd0, 32'd0);
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d  = rem_step;
                quot_d = quot_step;
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d  = DONE;
                    result_d = div_final(op_q, sign_a_q, sign_b_q, zero_q, ovf_q,
                                         a_raw_q, quot_step, rem_step);
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A flush drops whatever is in flight but leaves the last result visible.
        if (kill_i) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            op_q     <= DIV_DIVU;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            a_raw_q  <= 32'd0;
            b_abs_q  <= 32'd0;
            rem_q    <= 32'd0;
            quot_q   <= 32'd0;
            result_q <= 32'd0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            a_raw_q  <= a_raw_d;
            b_abs_q  <= b_abs_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            result_q <= result_d;
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign valid_o  = (state_q == DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_cv32e41s_div_iter.sv
// Self-checking bench for cv32e41s_div_iter: directed table, corner sequences,
// and randomized operations against an arithmetic reference model.
module tb_cv32e41s_div_iter;
    import cv32e41s_pkg::*;

    localparam int LAT_LIMIT = 100;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    div_opcode_e operator_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        kill_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;

    int n_checks = 0;
    int n_errors = 0;

    cv32e41s_div_iter #(.EARLY_OUT_EN(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .operator_i (operator_i),
        .op_a_i     (op_a_i),
        .op_b_i     (op_b_i),
        .kill_i     (kill_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .result_o   (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        div_opcode_e op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // RISC-V M-extension semantics expressed with native SV arithmetic.
    function automatic logic [31:0] ref_result(input div_opcode_e op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            DIV_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            DIV_REMU: return (b == 0) ? a : a % b;
            DIV_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000
                                      : 32'($signed(a) / $signed(b));
            default:  return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
        endcase
    endfunction

    function automatic int ref_latency(input div_opcode_e op, input logic [31:0] a,
                                       input logic [31:0] b);
        logic is_signed;
        is_signed = (op == DIV_DIV) || (op == DIV_REM);
        if (b == 0 || (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        return 33;
    endfunction

    task automatic accept(input div_opcode_e op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check("ready_before_accept", 32'(ready_o), 32'd1);
        valid_i = 1'b1; operator_i = op; op_a_i = a; op_b_i = b;
        @(posedge clk); #1;
        valid_i    = 1'b0;
        op_a_i     = $urandom;
        op_b_i     = $urandom;
        operator_i = div_opcode_e'($urandom_range(0, 3));
    endtask

    task automatic run_op(input div_opcode_e op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        accept(op, a, b);
        lat = 1;
        while (!valid_o && lat < LAT_LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result_o;
    endtask

    task automatic release_op();
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        check("idle_after_handshake", {30'd0, ready_o, valid_o}, 32'b10);
    endtask

    task automatic run_and_check(input string name, input div_opcode_e op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int          lat;
        run_op(op, a, b, res, lat);
        check({name, "_result"}, res, exp);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        release_op();
    endtask

    initial begin
        vec_t        vecs[12];
        logic [31:0] res;
        int          lat;
        bit          seen_valid;

        vecs[0]  = '{DIV_DIVU, 32'd100,        32'd7,          32'd14,         33};
        vecs[1]  = '{DIV_REMU, 32'd100,        32'd7,          32'd2,          33};
        vecs[2]  = '{DIV_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  33};
        vecs[3]  = '{DIV_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  33};
        vecs[4]  = '{DIV_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[5]  = '{DIV_REM,  32'd5,          32'd0,          32'd5,          1};
        vecs[6]  = '{DIV_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[7]  = '{DIV_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        vecs[8]  = '{DIV_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
        vecs[9]  = '{DIV_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1};
        vecs[10] = '{DIV_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
        vecs[11] = '{DIV_REMU, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  1};

        rst_n = 1'b0; valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b0;
        operator_i = DIV_DIVU; op_a_i = 32'd0; op_b_i = 32'd0;
        #12;
        check("reset_outputs", {29'd0, ready_o, valid_o, 1'b0}, 32'b100);
        check("reset_result", result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                          vecs[i].exp, vecs[i].lat);
        end

        // Back-pressure: result must hold while ready_i stays low.
        run_op(DIV_DIVU, 32'd1000, 32'd3, res, lat);
        check("bp_result", res, 32'd333);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid_held", 32'(valid_o), 32'd1);
            check("bp_result_held", result_o, 32'd333);
        end
        release_op();
        run_and_check("bp_next", DIV_REMU, 32'd1000, 32'd3, 32'd1, 33);

        // Kill during the tenth CALC cycle.
        accept(DIV_DIVU, 32'd1000, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        check("kill_precond_busy", 32'(ready_o), 32'd0);
        kill_i = 1'b1;
        @(posedge clk); #1;
        kill_i = 1'b0;
        check("kill_calc_idle", {30'd0, ready_o, valid_o}, 32'b10);
        seen_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid_o) seen_valid = 1'b1;
        end
        check("kill_calc_no_valid", 32'(seen_valid), 32'd0);
        run_and_check("after_kill", DIV_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

        // Kill in DONE beats ready_i; result stays on the bus.
        run_op(DIV_DIVU, 32'd50, 32'd5, res, lat);
        check("kill_done_pre", res, 32'd10);
        kill_i = 1'b1; ready_i = 1'b1;
        @(posedge clk); #1;
        kill_i = 1'b0; ready_i = 1'b0;
        check("kill_done_idle", {30'd0, ready_o, valid_o}, 32'b10);
        check("kill_done_result_kept", result_o, 32'd10);

        // Kill alongside a request: the request must not be taken.
        @(negedge clk);
        valid_i = 1'b1; kill_i = 1'b1; operator_i = DIV_DIV; op_a_i = 32'd5; op_b_i = 32'd0;
        @(posedge clk); #1;
        valid_i = 1'b0; kill_i = 1'b0;
        @(posedge clk); #1;
        check("kill_blocks_accept", {30'd0, ready_o, valid_o}, 32'b10);

        // Asynchronous reset mid-CALC.
        run_and_check("pre_reset", DIV_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 33);
        accept(DIV_DIVU, 32'd12345, 32'd6);
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("rst_mid_calc_state", {30'd0, ready_o, valid_o}, 32'b10);
        check("rst_mid_calc_result", result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_and_check("post_reset", DIV_REM, 32'hFFFF_FFF0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 33);

        // Random operations with biased operand classes.
        for (int i = 0; i < 80; i++) begin
            div_opcode_e op;
            logic [31:0] a;
            logic [31:0] b;
            op = div_opcode_e'($urandom_range(0, 3));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1;
                2:       b = 32'($urandom_range(2, 300));
                3:       b = -32'($urandom_range(1, 300));
                default: b = 32'($urandom);
            endcase
            run_and_check($sformatf("rnd%0d", i), op, a, b, ref_result(op, a, b),
                          ref_latency(op, a, b));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
